// File: rtl/frag_fifo.sv
// frag_fifo: elastic fragment buffer between the sample-test stage and the
// z-buffer/frame-buffer writer. Fragments are held in a circular buffer and
// presented through a registered head stage with a valid/ready handshake.
// halt_RnnnnL drops early, at DEPTH-SKID entries, so that samples already in
// flight upstream still fit. A push arriving while full and not popping is
// dropped and latches the sticky ovfl_RnnH flag.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   hit_R18S            fragment position (signed, AXIS components)
//   color_R18U          fragment color (COLORS channels)
//   hit_valid_R18H      push request
//   tri_first_R18H      fragment opens a new triangle
//   frag_ready_RnnH     downstream accepts the head fragment
//   frag_RnnS           head fragment position
//   frag_color_RnnU     head fragment color
//   frag_first_RnnH     head fragment opens a triangle
//   frag_valid_RnnH     head entry valid
//   halt_RnnnnL         0 = upstream must stall
//   ovfl_RnnH           sticky overflow error
//   count_RnnU          current occupancy
//
// Optional feature, macro FRAG_FIFO_TRI_CNT_EN:
//   tri_cnt_RnnU        fragments popped for the previous triangle
//   tri_cnt_valid_RnnH  one-cycle pulse qualifying tri_cnt_RnnU
module frag_fifo #(
  parameter int unsigned SIGFIG = 24,
  parameter int unsigned AXIS   = 3,
  parameter int unsigned COLORS = 3,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned SKID   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SIGFIG-1:0]   hit_R18S        [AXIS-1:0],
  input  logic        [SIGFIG-1:0]   color_R18U      [COLORS-1:0],
  input  logic                       hit_valid_R18H,
  input  logic                       tri_first_R18H,
  input  logic                       frag_ready_RnnH,
  output logic signed [SIGFIG-1:0]   frag_RnnS       [AXIS-1:0],
  output logic        [SIGFIG-1:0]   frag_color_RnnU [COLORS-1:0],
  output logic                       frag_first_RnnH,
  output logic                       frag_valid_RnnH,
  output logic                       halt_RnnnnL,
  output logic                       ovfl_RnnH,
  output logic [$clog2(DEPTH):0]     count_RnnU
`ifdef FRAG_FIFO_TRI_CNT_EN
  ,
  output logic [31:0]                tri_cnt_RnnU,
  output logic                       tri_cnt_valid_RnnH
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // storage (contents are don't-care after reset)
  logic signed [SIGFIG-1:0] r_mem_hit   [DEPTH-1:0][AXIS-1:0];
  logic        [SIGFIG-1:0] r_mem_col   [DEPTH-1:0][COLORS-1:0];
  logic                     r_mem_first [DEPTH-1:0];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] w_rd_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  logic signed [SIGFIG-1:0] r_head_hit [AXIS-1:0];
  logic        [SIGFIG-1:0] r_head_col [COLORS-1:0];
  logic                     r_head_first;
  logic                     r_valid;
  logic                     r_halt_n;
  logic                     r_ovfl;

  logic signed [SIGFIG-1:0] w_head_hit [AXIS-1:0];
  logic        [SIGFIG-1:0] w_head_col [COLORS-1:0];
  logic                     w_head_first;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_bypass;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_pop    = r_valid && frag_ready_RnnH;
  assign w_push   = hit_valid_R18H && (!w_full || w_pop);
  assign w_drop   = hit_valid_R18H && w_full && !w_pop;
  assign w_rd_nxt = w_pop ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
  // the slot the head moves to is being written this very cycle
  assign w_bypass = w_push && (r_wr_ptr == w_rd_nxt);

  // occupancy after this edge
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // next head entry: stored slot, or the incoming fragment when it lands there
  always_comb begin
    w_head_hit   = r_mem_hit[w_rd_nxt];
    w_head_col   = r_mem_col[w_rd_nxt];
    w_head_first = r_mem_first[w_rd_nxt];
    if (w_bypass) begin
      w_head_hit   = hit_R18S;
      w_head_col   = color_R18U;
      w_head_first = tri_first_R18H;
    end
  end

  // storage write
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_hit[r_wr_ptr]   <= hit_R18S;
      r_mem_col[r_wr_ptr]   <= color_R18U;
      r_mem_first[r_wr_ptr] <= tri_first_R18H;
    end
  end

  // pointers, occupancy, status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_halt_n <= 1'b1;
      r_ovfl   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      r_halt_n <= (w_count_nxt < CW'(DEPTH - SKID));
      if (w_drop) r_ovfl <= 1'b1;
    end
  end

  // registered head stage; holds while empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(AXIS); i++)   r_head_hit[i] <= '0;
      for (int i = 0; i < int'(COLORS); i++) r_head_col[i] <= '0;
      r_head_first <= 1'b0;
    end else if (w_count_nxt != '0) begin
      r_head_hit   <= w_head_hit;
      r_head_col   <= w_head_col;
      r_head_first <= w_head_first;
    end
  end

  assign frag_RnnS       = r_head_hit;
  assign frag_color_RnnU = r_head_col;
  assign frag_first_RnnH = r_head_first;
  assign frag_valid_RnnH = r_valid;
  assign halt_RnnnnL     = r_halt_n;
  assign ovfl_RnnH       = r_ovfl;
  assign count_RnnU      = r_count;

`ifdef FRAG_FIFO_TRI_CNT_EN
  logic [31:0] r_tri_acc;
  logic [31:0] r_tri_cnt;
  logic        r_tri_pulse;
  logic        r_tri_seen;

  // per-triangle pop counter; the first triangle start after reset has no
  // predecessor to report
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tri_acc   <= '0;
      r_tri_cnt   <= '0;
      r_tri_pulse <= 1'b0;
      r_tri_seen  <= 1'b0;
    end else begin
      r_tri_pulse <= 1'b0;
      if (w_pop) begin
        if (r_head_first) begin
          r_tri_acc  <= 32'd1;
          r_tri_seen <= 1'b1;
          if (r_tri_seen) begin
            r_tri_cnt   <= r_tri_acc;
            r_tri_pulse <= 1'b1;
          end
        end else begin
          r_tri_acc <= r_tri_acc + 32'd1;
        end
      end
    end
  end

  assign tri_cnt_RnnU       = r_tri_cnt;
  assign tri_cnt_valid_RnnH = r_tri_pulse;
`endif

endmodule

// File: tb/tb_frag_fifo.sv
module tb_frag_fifo;

  localparam int unsigned SIGFIG = 24;
  localparam int unsigned AXIS   = 3;
  localparam int unsigned COLORS = 3;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned SKID   = 4;

  typedef struct packed {
    logic [2:0][23:0] h;
    logic [2:0][23:0] c;
    logic             f;
  } frag_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [SIGFIG-1:0] hit_R18S        [AXIS-1:0];
  logic        [SIGFIG-1:0] color_R18U      [COLORS-1:0];
  logic                     hit_valid_R18H  = 1'b0;
  logic                     tri_first_R18H  = 1'b0;
  logic                     frag_ready_RnnH = 1'b0;
  logic signed [SIGFIG-1:0] frag_RnnS       [AXIS-1:0];
  logic        [SIGFIG-1:0] frag_color_RnnU [COLORS-1:0];
  logic                     frag_first_RnnH;
  logic                     frag_valid_RnnH;
  logic                     halt_RnnnnL;
  logic                     ovfl_RnnH;
  logic [4:0]               count_RnnU;
`ifdef FRAG_FIFO_TRI_CNT_EN
  logic [31:0]              tri_cnt_RnnU;
  logic                     tri_cnt_valid_RnnH;
`endif

  frag_fifo #(.SIGFIG(SIGFIG), .AXIS(AXIS), .COLORS(COLORS), .DEPTH(DEPTH), .SKID(SKID)) dut (
    .clk(clk), .rst(rst),
    .hit_R18S(hit_R18S), .color_R18U(color_R18U),
    .hit_valid_R18H(hit_valid_R18H), .tri_first_R18H(tri_first_R18H),
    .frag_ready_RnnH(frag_ready_RnnH),
    .frag_RnnS(frag_RnnS), .frag_color_RnnU(frag_color_RnnU),
    .frag_first_RnnH(frag_first_RnnH), .frag_valid_RnnH(frag_valid_RnnH),
    .halt_RnnnnL(halt_RnnnnL), .ovfl_RnnH(ovfl_RnnH), .count_RnnU(count_RnnU)
`ifdef FRAG_FIFO_TRI_CNT_EN
    , .tri_cnt_RnnU(tri_cnt_RnnU), .tri_cnt_valid_RnnH(tri_cnt_valid_RnnH)
`endif
  );

  always #5 clk = ~clk;

  // reference model state
  frag_t scb[$];
  int    m_count = 0;
  bit    m_ovfl  = 1'b0;
  int    m_acc   = 0;
  bit    m_seen  = 1'b0;
  bit    m_pulse = 1'b0;
  int    m_pulse_val = 0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic frag_t rnd_frag(input bit first);
    frag_t d;
    for (int i = 0; i < 3; i++) begin
      d.h[i] = 24'($urandom);
      d.c[i] = 24'($urandom);
    end
    d.f = first;
    return d;
  endfunction

  function automatic frag_t head_now();
    frag_t g;
    for (int i = 0; i < 3; i++) begin
      g.h[i] = frag_RnnS[i];
      g.c[i] = frag_color_RnnU[i];
    end
    g.f = frag_first_RnnH;
    return g;
  endfunction

  // monitor: status against the model, head payload against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      frag_t exp_f;
      chk("count", 160'(count_RnnU), 160'(m_count));
      chk("valid", 160'(frag_valid_RnnH), 160'(m_count != 0));
      chk("halt", 160'(halt_RnnnnL), 160'(m_count < int'(DEPTH - SKID)));
      chk("ovfl", 160'(ovfl_RnnH), 160'(m_ovfl));
`ifdef FRAG_FIFO_TRI_CNT_EN
      chk("tri_pulse", 160'(tri_cnt_valid_RnnH), 160'(m_pulse));
      if (m_pulse) chk("tri_cnt", 160'(tri_cnt_RnnU), 160'(m_pulse_val));
`endif
      m_pulse = 1'b0;
      if (frag_valid_RnnH && frag_ready_RnnH) begin
        if (scb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pop_empty got=head exp=no_entry");
        end else begin
          exp_f = scb.pop_front();
          chk("payload", 160'(head_now()), 160'(exp_f));
          if (exp_f.f) begin
            if (m_seen) begin
              m_pulse     = 1'b1;
              m_pulse_val = m_acc;
            end
            m_seen = 1'b1;
            m_acc  = 1;
          end else begin
            m_acc++;
          end
        end
      end
    end
  end

  // one clock of stimulus; starts and ends just after a rising edge
  task automatic step(input bit v, input bit rdy, input frag_t d);
    bit pop;
    bit pushok;
    hit_valid_R18H  = v;
    frag_ready_RnnH = rdy;
    tri_first_R18H  = d.f;
    for (int i = 0; i < 3; i++) begin
      hit_R18S[i]   = d.h[i];
      color_R18U[i] = d.c[i];
    end
    pop    = (m_count != 0) && rdy;
    pushok = v && ((m_count < int'(DEPTH)) || pop);
    if (pushok) scb.push_back(d);
    @(posedge clk);
    #1;
    m_count = m_count + int'(pushok) - int'(pop);
    if (v && !pushok) m_ovfl = 1'b1;
  endtask

  task automatic clear_model();
    scb.delete();
    m_count = 0;
    m_ovfl  = 1'b0;
    m_acc   = 0;
    m_seen  = 1'b0;
    m_pulse = 1'b0;
  endtask

  // asynchronous reset taken mid-cycle; outputs checked before any edge
  task automatic do_reset();
    #2;
    rst = 1'b1;
    hit_valid_R18H  = 1'b0;
    frag_ready_RnnH = 1'b0;
    #1;
    chk("rst_valid", 160'(frag_valid_RnnH), 160'(0));
    chk("rst_count", 160'(count_RnnU), 160'(0));
    chk("rst_halt", 160'(halt_RnnnnL), 160'(1));
    chk("rst_ovfl", 160'(ovfl_RnnH), 160'(0));
    chk("rst_first", 160'(frag_first_RnnH), 160'(0));
    chk("rst_head", 160'(head_now()), 160'(0));
`ifdef FRAG_FIFO_TRI_CNT_EN
    chk("rst_tri_cnt", 160'(tri_cnt_RnnU), 160'(0));
    chk("rst_tri_pulse", 160'(tri_cnt_valid_RnnH), 160'(0));
`endif
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    frag_t d;
    frag_t z;
    z = '0;
    for (int i = 0; i < 3; i++) begin
      hit_R18S[i]   = '0;
      color_R18U[i] = '0;
    end
    @(posedge clk);
    #1;
    do_reset();

    // single fragment, ready held high
    d.h[0] = 24'd100; d.h[1] = 24'd200; d.h[2] = 24'd5;
    d.c[0] = 24'd1;   d.c[1] = 24'd2;   d.c[2] = 24'd3;
    d.f = 1'b1;
    step(1'b1, 1'b1, d);
    step(1'b0, 1'b1, z);
    step(1'b0, 1'b1, z);

    // halt threshold at 12 entries, released by one pop
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, rnd_frag(i == 0));
    step(1'b0, 1'b0, z);
    step(1'b0, 1'b1, z);
    step(1'b0, 1'b0, z);

    // overflow: 16 fit, 17th dropped, sticky flag, drain in order
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, rnd_frag(1'(i % 3 == 0)));
    step(1'b0, 1'b0, z);
    for (int i = 0; i < 18; i++) step(1'b0, 1'b1, z);

    // full with simultaneous push and pop across pointer wrap
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, rnd_frag(1'(i % 4 == 0)));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, rnd_frag(1'(i % 5 == 0)));
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, z);

    // asynchronous reset with 7 entries queued
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, rnd_frag(1'b0));
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, z);

    // triangles of 3, 5 and 1 hits drained with ready high
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, rnd_frag(i == 0));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, rnd_frag(i == 0));
    step(1'b1, 1'b1, rnd_frag(1'b1));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, z);

    // randomized traffic with varying push/pop pressure
    do_reset();
    for (int ph = 0; ph < 6; ph++) begin
      int pv;
      int pr;
      pv = 20 + 15 * ph;
      pr = 90 - 15 * ph;
      for (int i = 0; i < 400; i++) begin
        bit v;
        bit r;
        v = ($urandom_range(99) < pv);
        r = ($urandom_range(99) < pr);
        step(v, r, rnd_frag($urandom_range(3) == 0));
      end
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, z);
    chk("scb_empty", 160'(scb.size()), 160'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frag_fifo.md
Name: frag_fifo

Overview:
- Elastic fragment buffer directly downstream of the sample-test stage (R18).
- Accepts hit fragments (position, color, first-of-triangle tag) from sample test and holds them for the z-buffer/frame-buffer writer under a valid/ready handshake.
- Raises backpressure early through an active-low halt to upstream, so in-flight pipeline samples are never lost.
- Flags any fragment that arrives while full with a sticky error bit.

Parameters:
SIGFIG, 24, bits per position/color component
AXIS, 3, position components per fragment (x,y,z)
COLORS, 3, color channels per fragment
DEPTH, 16, fragment entries; power of two, >= 4
SKID, 4, entries reserved for in-flight upstream samples; halt asserts at DEPTH-SKID occupancy; 1 <= SKID < DEPTH

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
hit_R18S  input  SIGFIG x AXIS (signed, unpacked [AXIS-1:0])  fragment position
color_R18U  input  SIGFIG x COLORS (unsigned, unpacked [COLORS-1:0])  fragment color
hit_valid_R18H  input  1  push request
tri_first_R18H  input  1  fragment is first hit of a new triangle; meaningful only with hit_valid_R18H
frag_ready_RnnH  input  1  downstream accepts the head fragment this cycle
frag_RnnS  output  SIGFIG x AXIS  head fragment position
frag_color_RnnU  output  SIGFIG x COLORS  head fragment color
frag_first_RnnH  output  1  head fragment is first of its triangle
frag_valid_RnnH  output  1  head entry valid
halt_RnnnnL  output  1  0 = upstream must stall
ovfl_RnnH  output  1  sticky overflow error
count_RnnU  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, rst=1) clears pointers and count. Output values under reset:
  - frag_valid_RnnH=0, frag_first_RnnH=0, ovfl_RnnH=0, count_RnnU=0, halt_RnnnnL=1.
  - frag_RnnS and frag_color_RnnU = 0.
  - Storage contents are don't-care.
- Push: hit_valid_R18H && (!full || pop) writes {hit, color, first} at wr_ptr; wr_ptr increments.
- Pop: frag_valid_RnnH && frag_ready_RnnH; rd_ptr increments.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- full = (count==DEPTH); empty = (count==0).
- Count update: push only → +1; pop only → −1; both or neither → unchanged.
- Simultaneous push and pop while full: push accepted, count stays DEPTH.
- Simultaneous push and pop with count==1: head advances to the new entry; frag_valid_RnnH stays 1.
- Latency: a push into an empty FIFO makes frag_valid_RnnH=1 on the next rising edge. No combinational path from hit_valid_R18H to frag_valid_RnnH.
- Head outputs are registered and stable while frag_valid_RnnH=1 && frag_ready_RnnH=0.
- frag_ready_RnnH while frag_valid_RnnH=0 is ignored.
- halt_RnnnnL is registered: next value = 0 when next count >= DEPTH-SKID, else 1. Deasserts (returns to 1) the cycle after count drops below DEPTH-SKID.
- Overflow: hit_valid_R18H && full && !pop drops the fragment; ovfl_RnnH is set next cycle and stays set until reset. Pointers and count are unchanged.
- Fragment order is strictly FIFO; tri_first is carried with its entry unchanged.
- Data width: no arithmetic on payload; bit-exact pass-through, sign preserved.

Optional Feature:
- Macro: FRAG_FIFO_TRI_CNT_EN.
- When defined, adds ports:
  - tri_cnt_RnnU (output, 32): number of fragments popped for the previous triangle.
  - tri_cnt_valid_RnnH (output, 1): one-cycle pulse.
- Counter behaviour:
  - The counter increments on every pop.
  - On a pop with frag_first_RnnH=1, the pre-increment count is presented on tri_cnt_RnnU with a pulse the next cycle, and the counter restarts at 1.
  - The first triangle after reset produces no pulse.
  - Both new outputs reset to 0.
- Triangles with zero hits are invisible to the counter.
- When the macro is undefined, these ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, push one fragment (hit=(100,200,5), color=(1,2,3), first=1), ready held 1 → frag_valid_RnnH=1 exactly one cycle after push with identical payload and first=1; count returns to 0 after pop.
- ready=0, push 12 fragments with DEPTH=16, SKID=4 → halt_RnnnnL=0 from the cycle after the 12th push; pop 1 → halt_RnnnnL=1 one cycle later.
- ready=0, push 16 then a 17th → count=16, ovfl_RnnH=1 next cycle and held; popping 16 returns fragments 1–16 in order; fragment 17 is never emitted.
- Full FIFO, push and pop in the same cycle for 20 cycles → count stays 16, ovfl_RnnH=0, outputs appear in order across pointer wrap.
- Assert rst mid-stream with 7 entries queued → frag_valid_RnnH=0, count_RnnU=0, halt_RnnnnL=1, ovfl_RnnH=0 immediately (asynchronous), no stale fragment after release.
- With FRAG_FIFO_TRI_CNT_EN: triangles of 3, 5 and 1 hits drained with ready=1 → pulses carrying 3 then 5; no pulse for the first triangle start.
